// File: rtl/seg_pkg.sv
// Shared types, constants and the hex-to-segment decode for the seven-segment scan driver.
package seg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_OFF = 7'b1111111;

    // Active-low {a,b,c,d,e,f,g} patterns indexed by hex value.
    localparam seg_t SEG_HEX [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    function automatic seg_t seg_hex(input logic [3:0] nibble);
        return SEG_HEX[nibble];
    endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Display-register side inputs and board-pin side outputs of the scan driver.
interface seg_scan_driver_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    import seg_pkg::*;

    logic [4*NUM_DIGITS-1:0] data_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    load;
    logic                    lz_en;
    logic                    enable;
    seg_t                    seg;
    logic                    dp_n;
    logic [NUM_DIGITS-1:0]   an;
    logic                    frame_done;

    modport master (
        output data_in, dp_in, load, lz_en, enable,
        input  seg, dp_n, an, frame_done
    );

    modport slave (
        input  data_in, dp_in, load, lz_en, enable,
        output seg, dp_n, an, frame_done
    );

endinterface

// File: rtl/seg_prescaler.sv
// Free-running 0..DIV-1 counter with a single-cycle tick on the terminal count.
module seg_prescaler #(
    parameter int unsigned DIV   = 100000,
    parameter int unsigned CNT_W = $clog2(DIV)
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] count,
    output logic             tick
);

    logic [CNT_W-1:0] count_q;

    assign count = count_q;
    assign tick  = (count_q == CNT_W'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (tick) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with frame-synchronous double buffering,
// per-slot blanking and leading-zero suppression.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    seg_scan_driver_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

    logic [CNT_W-1:0]        count;
    logic                    tick;
    logic                    wrap;
    logic [IDX_W-1:0]        idx_q;
    logic [4*NUM_DIGITS-1:0] pending_data_q, active_data_q;
    logic [NUM_DIGITS-1:0]   pending_dp_q, active_dp_q;
    logic                    pending_valid_q;

    logic [3:0]            nibble;
    logic                  digit_dp;
    logic                  upper_zero;
    logic                  suppressed;
    logic                  blank;
    logic                  lit;
    logic                  on;
    seg_t                  seg_d, seg_q;
    logic [NUM_DIGITS-1:0] an_d, an_q;
    logic                  dp_n_d, dp_n_q;
    logic                  frame_done_q;

    seg_prescaler #(
        .DIV   (REFRESH_DIV),
        .CNT_W (CNT_W)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .count (count),
        .tick  (tick)
    );

    assign wrap = tick && (idx_q == IDX_W'(NUM_DIGITS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
        end else if (tick) begin
            idx_q <= wrap ? '0 : idx_q + 1'b1;
        end
    end

    // A load coinciding with the frame wrap bypasses the pending buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_data_q  <= '0;
            pending_dp_q    <= '0;
            pending_valid_q <= 1'b0;
            active_data_q   <= '0;
            active_dp_q     <= '0;
        end else if (bus.load && wrap) begin
            active_data_q   <= bus.data_in;
            active_dp_q     <= bus.dp_in;
            pending_valid_q <= 1'b0;
        end else begin
            if (wrap && pending_valid_q) begin
                active_data_q   <= pending_data_q;
                active_dp_q     <= pending_dp_q;
                pending_valid_q <= 1'b0;
            end
            if (bus.load) begin
                pending_data_q  <= bus.data_in;
                pending_dp_q    <= bus.dp_in;
                pending_valid_q <= 1'b1;
            end
        end
    end

    always_comb begin
        nibble     = '0;
        digit_dp   = 1'b0;
        upper_zero = 1'b1;
        suppressed = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                nibble   = active_data_q[4*k +: 4];
                digit_dp = active_dp_q[k];
            end
        end
        // Walk down from the top digit; upper_zero covers nibbles k..NUM_DIGITS-1.
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            upper_zero = upper_zero && (active_data_q[4*k +: 4] == 4'h0);
            if (idx_q == IDX_W'(k) && upper_zero) begin
                suppressed = bus.lz_en;
            end
        end
    end

    always_comb begin
        blank  = (count < CNT_W'(BLANK_CYCLES));
        lit    = bus.enable && !suppressed;
        on     = lit && !blank;
        seg_d  = lit ? seg_hex(nibble) : SEG_OFF;
        an_d   = on ? ~(NUM_DIGITS'(1) << idx_q) : '1;
        dp_n_d = on ? ~digit_dp : 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q        <= SEG_OFF;
            an_q         <= '1;
            dp_n_q       <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            seg_q        <= seg_d;
            an_q         <= an_d;
            dp_n_q       <= dp_n_d;
            frame_done_q <= wrap;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.an         = an_q;
    assign bus.dp_n       = dp_n_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: directed scenarios plus random loads against a
// position-based reference model of the scanned display.
module tb_seg_scan_driver;

    localparam int N     = 4;
    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = N * DIV;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    seg_scan_driver_if #(.NUM_DIGITS(N)) bus ();

    seg_scan_driver #(
        .NUM_DIGITS   (N),
        .REFRESH_DIV  (DIV),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vecs = 0;
    int errs = 0;

    // Model: pos = edges since reset release; buffers follow the load/frame rules directly.
    int          pos;
    logic [15:0] m_act, m_pend;
    logic [3:0]  m_act_dp, m_pend_dp;
    bit          m_pv;
    logic [6:0]  hex_tab [16];
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp, exp_fd;

    task automatic model_reset();
        pos       = 0;
        m_act     = '0;
        m_pend    = '0;
        m_act_dp  = '0;
        m_pend_dp = '0;
        m_pv      = 0;
        exp_an    = 4'hF;
        exp_seg   = 7'h7F;
        exp_dp    = 1'b1;
        exp_fd    = 1'b0;
    endtask

    task automatic model_edge();
        int         digit;
        int         phase;
        bit         wrap, supp, lit, on;
        logic [3:0] nib;
        digit = (pos / DIV) % N;
        phase = pos % DIV;
        wrap  = (pos % FRAME) == FRAME - 1;
        nib   = 4'(m_act >> (4 * digit));
        supp  = bus.lz_en && digit != 0 && ((m_act >> (4 * digit)) == 16'h0);
        lit   = bus.enable && !supp;
        on    = lit && phase >= BLANK;
        exp_seg = lit ? hex_tab[nib] : 7'h7F;
        exp_an  = on ? ~(4'b0001 << digit) : 4'hF;
        exp_dp  = on ? ~m_act_dp[digit] : 1'b1;
        exp_fd  = wrap;
        if (bus.load && wrap) begin
            m_act    = bus.data_in;
            m_act_dp = bus.dp_in;
            m_pv     = 0;
        end else if (bus.load) begin
            m_pend    = bus.data_in;
            m_pend_dp = bus.dp_in;
            m_pv      = 1;
        end else if (wrap && m_pv) begin
            m_act    = m_pend;
            m_act_dp = m_pend_dp;
            m_pv     = 0;
        end
        pos++;
    endtask

    task automatic check_out();
        vecs++;
        assert (bus.an === exp_an) else begin
            errs++;
            $error("FAIL an pos=%0d got %b want %b", pos, bus.an, exp_an);
        end
        vecs++;
        assert (bus.seg === exp_seg) else begin
            errs++;
            $error("FAIL seg pos=%0d got %b want %b", pos, bus.seg, exp_seg);
        end
        vecs++;
        assert (bus.dp_n === exp_dp) else begin
            errs++;
            $error("FAIL dp_n pos=%0d got %b want %b", pos, bus.dp_n, exp_dp);
        end
        vecs++;
        assert (bus.frame_done === exp_fd) else begin
            errs++;
            $error("FAIL frame_done pos=%0d got %b want %b", pos, bus.frame_done, exp_fd);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge();
        #1;
        check_out();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic run_to(input int ph);
        int guard = 0;
        while ((pos % FRAME) != ph && guard < 2 * FRAME) begin
            tick();
            guard++;
        end
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dp);
        bus.data_in = d;
        bus.dp_in   = dp;
        bus.load    = 1'b1;
        tick();
        bus.load    = 1'b0;
    endtask

    initial begin
        hex_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                    7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
                    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        rst_n       = 1'b1;
        bus.data_in = '0;
        bus.dp_in   = '0;
        bus.load    = 1'b0;
        bus.lz_en   = 1'b0;
        bus.enable  = 1'b1;

        // Reset state, before any clock edge
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_out();
        run(2);
        rst_n = 1'b1;

        // Basic scan of 12AF after it becomes active at the first wrap
        do_load(16'h12AF, 4'b0000);
        run(2 * FRAME);

        // Mid-frame load lands next frame; load on the wrap edge lands immediately
        run_to(20);
        do_load(16'h1234, 4'b0000);
        run(FRAME);
        run_to(FRAME - 1);
        do_load(16'h9C0E, 4'b1001);
        run(FRAME);

        // Repeated loads in one frame: last one wins
        run_to(3);
        do_load(16'h1111, 4'b0000);
        run(4);
        do_load(16'h0E5D, 4'b0100);
        run(2 * FRAME);

        // Leading-zero suppression
        bus.lz_en = 1'b1;
        do_load(16'h0040, 4'b1111);
        run(2 * FRAME);
        do_load(16'h0000, 4'b0001);
        run(2 * FRAME);
        bus.lz_en = 1'b0;

        // Display disabled while scanning continues, then decimal point on digit 1
        bus.enable = 1'b0;
        do_load(16'h8888, 4'b0010);
        run(2 * FRAME);
        bus.enable = 1'b1;
        run(FRAME);

        // Random loads, lz_en and enable changes
        for (int i = 0; i < 480; i++) begin
            if ($urandom_range(7) == 0) do_load(16'($urandom), 4'($urandom));
            else tick();
            if ($urandom_range(31) == 0) bus.lz_en = 1'($urandom);
            if ($urandom_range(63) == 0) bus.enable = ~bus.enable;
        end
        bus.enable = 1'b1;
        bus.lz_en  = 1'b0;
        do_load(16'hBEEF, 4'b1010);
        run(2 * FRAME);

        // Asynchronous reset in the middle of slot 2
        run_to(18);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_out();
        run(2);
        rst_n = 1'b1;
        run(FRAME + 8);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
